// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-ported memory between instruction fetch and
// load/store, forwarding one request at a time over a req/ack handshake with timeout.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_len,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_len,
    output logic        mem_signed,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic               last_d;
    logic               owner_d;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               grant_if;
    logic               grant_d;
    logic               d_illegal;
    logic               illegal;

    // Tie goes to the port that was not granted last.
    always_comb begin
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        d_illegal = 1'b0;
        illegal   = 1'b0;
        if (state == IDLE) begin
            grant_if = if_req && (!d_req || last_d);
            grant_d  = d_req && (!if_req || !last_d);
        end
        case (d_len)
            2'b00:   d_illegal = 1'b1;
            2'b10:   d_illegal = d_addr[0];
            2'b11:   d_illegal = (d_addr[1:0] != 2'b00);
            default: d_illegal = 1'b0;
        endcase
        illegal = grant_d ? d_illegal : (if_addr[1:0] != 2'b00);
    end

    assign if_ready = grant_if;
    assign d_ready  = grant_d;
    assign if_rdata = rdata_q;
    assign d_rdata  = rdata_q;
    assign if_err   = err_q;
    assign d_err    = err_q;

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state      <= IDLE;
            last_d     <= 1'b1;
            owner_d    <= 1'b0;
            cnt        <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_len    <= 2'b00;
            mem_signed <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if || grant_d) begin
                        owner_d    <= grant_d;
                        last_d     <= grant_d;
                        cnt        <= '0;
                        mem_we     <= grant_d ? d_we : 1'b0;
                        mem_len    <= grant_d ? d_len : 2'b11;
                        mem_signed <= grant_d ? d_signed : 1'b0;
                        mem_addr   <= grant_d ? d_addr : if_addr;
                        mem_wdata  <= grant_d ? d_wdata : 32'd0;
                        if (illegal) begin
                            state    <= RESP;
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                            if_valid <= grant_if;
                            d_valid  <= grant_d;
                        end else begin
                            state   <= BUSY;
                            mem_req <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        err_q    <= 1'b0;
                        rdata_q  <= mem_we ? 32'd0 : mem_rdata;
                        if_valid <= !owner_d;
                        d_valid  <= owner_d;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                        if_valid <= !owner_d;
                        d_valid  <= owner_d;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: predicts each transaction's schedule
// (grant, memory window, response cycle, data) from the arbitration and timeout rules.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_len;
    logic        d_signed;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .SYS_clk(clk), .SYS_reset_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pending requester state (held stable until accepted).
    bit        f_pend = 0;
    bit [31:0] f_a = 0;
    bit        dp = 0;
    bit        dw = 0;
    bit [1:0]  dl = 0;
    bit        ds = 0;
    bit [31:0] da = 0;
    bit [31:0] dwd = 0;

    // Transaction schedule model.
    int        cyc = 0;
    int        free_at = 0;
    bit        last_d = 1;
    bit        active = 0;
    int        t_acc = 0;
    int        t_k = 0;
    int        t_end = 0;
    bit        t_own = 0;
    bit        t_legal = 0;
    bit        t_we = 0;
    bit [1:0]  t_len = 0;
    bit        t_sg = 0;
    bit [31:0] t_addr = 0;
    bit [31:0] t_wd = 0;
    bit [31:0] t_data = 0;

    bit gen_on = 1;
    bit force_pair = 0;
    int force_k = 0;

    function automatic bit legal_data(input bit [1:0] len, input bit [31:0] a);
        case (len)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return a[0] == 1'b0;
            default: return a[1:0] == 2'b00;
        endcase
    endfunction

    function automatic int mem_cycles(input int k);
        return (k < int'(TO)) ? k : int'(TO);
    endfunction

    task automatic new_fetch(input bit aligned);
        bit [31:0] r;
        r = $urandom;
        f_pend = 1;
        f_a = (aligned || $urandom_range(0, 4) != 0) ? {r[31:2], 2'b00} : r;
    endtask

    task automatic new_data(input bit aligned);
        bit [31:0] r;
        r = $urandom;
        dp  = 1;
        dw  = 1'($urandom_range(0, 1));
        ds  = 1'($urandom_range(0, 1));
        dwd = $urandom;
        dl  = aligned ? 2'b11 : (($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3)));
        da  = (aligned || $urandom_range(0, 2) != 0) ? {r[31:2], 2'b00} : r;
    endtask

    task automatic drive_inputs();
        if_req   = f_pend;
        if_addr  = f_a;
        d_req    = dp;
        d_we     = dw;
        d_len    = dl;
        d_signed = ds;
        d_addr   = da;
        d_wdata  = dwd;
        mem_ack  = active && t_legal && t_k <= int'(TO) && cyc == t_acc + t_k;
        mem_rdata = mem_ack ? t_data : $urandom;
    endtask

    // One clock cycle: drive, then predict and compare at the falling edge.
    task automatic step();
        bit ex_ifr;
        bit ex_dr;
        bit ex_mreq;
        bit ex_err;
        @(posedge clk);
        #1;
        cyc++;
        if (gen_on) begin
            if (!f_pend && (force_pair || $urandom_range(0, 2) == 0)) new_fetch(force_pair);
            if (!dp && (force_pair || $urandom_range(0, 2) == 0)) new_data(force_pair);
        end
        drive_inputs();
        @(negedge clk);
        ex_ifr = 0;
        ex_dr  = 0;
        if (cyc >= free_at && (f_pend || dp)) begin
            ex_dr   = dp && (!f_pend || !last_d);
            ex_ifr  = !ex_dr;
            active  = 1;
            t_acc   = cyc;
            t_own   = ex_dr;
            t_legal = ex_dr ? legal_data(dl, da) : (f_a[1:0] == 2'b00);
            t_we    = ex_dr ? dw : 1'b0;
            t_len   = ex_dr ? dl : 2'b11;
            t_sg    = ex_dr ? ds : 1'b0;
            t_addr  = ex_dr ? da : f_a;
            t_wd    = dwd;
            t_k     = (force_k != 0) ? force_k : $urandom_range(1, TO + 2);
            t_data  = $urandom;
            t_end   = cyc + (t_legal ? mem_cycles(t_k) : 0) + 1;
            free_at = t_end + 1;
            last_d  = ex_dr;
        end
        ex_mreq = active && t_legal && cyc > t_acc && cyc <= t_acc + mem_cycles(t_k);
        check("if_ready", 32'(if_ready), 32'(ex_ifr));
        check("d_ready", 32'(d_ready), 32'(ex_dr));
        check("mem_req", 32'(mem_req), 32'(ex_mreq));
        check("if_valid", 32'(if_valid), 32'(active && cyc == t_end && !t_own));
        check("d_valid", 32'(d_valid), 32'(active && cyc == t_end && t_own));
        if (active && t_legal && cyc == t_acc + 1) begin
            check("mem_addr", mem_addr, t_addr);
            check("mem_len", 32'(mem_len), 32'(t_len));
            check("mem_we", 32'(mem_we), 32'(t_we));
            check("mem_signed", 32'(mem_signed), 32'(t_sg));
            if (t_own) check("mem_wdata", mem_wdata, t_wd);
        end
        if (active && cyc == t_end) begin
            ex_err = !t_legal || t_k > int'(TO);
            if (t_own) begin
                check("d_err", 32'(d_err), 32'(ex_err));
                check("d_rdata", d_rdata, (ex_err || t_we) ? 32'd0 : t_data);
            end else begin
                check("if_err", 32'(if_err), 32'(ex_err));
                check("if_rdata", if_rdata, ex_err ? 32'd0 : t_data);
            end
        end
        if (ex_ifr) f_pend = 0;
        if (ex_dr) dp = 0;
    endtask

    task automatic drain();
        int n;
        gen_on = 0;
        n = 0;
        while ((f_pend || dp || cyc < free_at) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'd1, 32'd0);
        gen_on = 1;
    endtask

    task automatic clear_inputs();
        f_pend = 0;
        dp = 0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_len = 0;
        d_signed = 0; d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'({if_valid, d_valid}), 32'd0);
        check("rst_rdata", if_rdata | d_rdata, 32'd0);
        check("rst_err", 32'({if_err, d_err}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous contention with one-cycle acks: fetch, data, fetch, data...
        force_pair = 1;
        force_k = 1;
        repeat (14) step();
        force_pair = 0;
        force_k = 0;

        repeat (1500) step();
        drain();

        // Reset while a load is waiting on memory.
        gen_on = 0;
        dp = 1; dw = 0; dl = 2'b11; ds = 0; da = 32'h0000_2000; dwd = 0;
        force_k = TO + 2;
        repeat (3) step();
        force_k = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_valid", 32'({if_valid, d_valid}), 32'd0);
        clear_inputs();
        active = 0;
        last_d = 1;
        free_at = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First tie after reset must go to fetch.
        f_pend = 1; f_a = 32'h0000_1000;
        dp = 1; dw = 0; dl = 2'b10; ds = 1; da = 32'h0000_2002; dwd = 0;
        force_k = 2;
        step();
        drain();
        force_k = 0;
        repeat (200) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
